// File: rtl/zram_writer_pkg.sv
// Shared types and widths for the zram write-side loader.
package zram_writer_pkg;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 8;
  localparam int COUNT_W = 17;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WRITE,
    TAIL,
    VERIFY,
    CHECK
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/zram_writer_if.sv
// Loader-side valid/ready write stream feeding zram_writer.
interface zram_writer_if;
  import zram_writer_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_address;
  logic [DATA_W-1:0] in_data;

  modport master (output in_valid, output in_address, output in_data, input in_ready);
  modport slave  (input in_valid, input in_address, input in_data, output in_ready);

endinterface

// File: rtl/zram_writer_fifo.sv
// Synchronous request FIFO of {address, data} entries; FIFO_DEPTH must be a power of 2.
module zram_writer_fifo
  import zram_writer_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          push,
  input  entry_t                        push_entry,
  input  logic                          pop,
  output entry_t                        head,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  entry_t             storage [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  // A pop frees a slot on the same edge, so a full FIFO may still take a push.
  assign do_push = push && (!full || do_pop);
  assign head    = storage[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clock) begin
    if (do_push) storage[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/zram_writer.sv
// Buffers loader writes and issues them on zram port A after taking it from tz80 via hold_req/hold_ack.
// Optional read-back check of every write is enabled by defining ZRAM_WRITER_VERIFY_EN.
module zram_writer
  import zram_writer_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int HOLD_TAIL  = 4
) (
  input  logic                clock,
  input  logic                reset,
  zram_writer_if.slave        in_bus,
  output logic                hold_req,
  input  logic                hold_ack,
  input  logic [ADDR_W-1:0]   cpu_address,
  input  logic [DATA_W-1:0]   cpu_o_data,
  input  logic                cpu_we,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W-1:0]   mem_data,
  output logic                mem_we,
  output logic                busy,
  output logic [COUNT_W-1:0]  wr_count
`ifdef ZRAM_WRITER_VERIFY_EN
  ,
  input  logic [DATA_W-1:0]   mem_q,
  output logic                verify_err,
  output logic [ADDR_W-1:0]   err_address
`endif
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int TAIL_W = (HOLD_TAIL < 1) ? 1 : $clog2(HOLD_TAIL + 1);
  localparam logic [COUNT_W-1:0] WR_COUNT_MAX = COUNT_W'(65536);

  state_e             state, state_next;
  entry_t             head;
  logic               full, empty, push, pop, wr_fire;
  logic [CNT_W-1:0]   count;
  logic [TAIL_W-1:0]  tail_cnt;
  logic               tail_load, tail_dec;
  logic [ADDR_W-1:0]  wr_address;
  logic [DATA_W-1:0]  wr_data;

  assign in_bus.in_ready = !full;
  assign push            = in_bus.in_valid && in_bus.in_ready;

  zram_writer_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_entry ({in_bus.in_address, in_bus.in_data}),
    .pop        (pop),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .count      (count)
  );

`ifdef ZRAM_WRITER_VERIFY_EN
  entry_t last_wr;
  logic   chk;
`else
  logic   drains;
  // This pop empties the FIFO unless a new entry lands on the same edge.
  assign drains = (count == CNT_W'(1)) && !push;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    wr_fire    = 1'b0;
    tail_load  = 1'b0;
    tail_dec   = 1'b0;
`ifdef ZRAM_WRITER_VERIFY_EN
    chk        = 1'b0;
`endif
    case (state)
      IDLE: if (!empty) state_next = REQ;
      REQ:  if (hold_ack) state_next = WRITE;
      WRITE: begin
        if (!hold_ack) begin
          state_next = REQ;
        end else if (!empty) begin
          wr_fire = 1'b1;
          pop     = 1'b1;
`ifdef ZRAM_WRITER_VERIFY_EN
          state_next = VERIFY;
`else
          if (drains) begin
            state_next = TAIL;
            tail_load  = 1'b1;
          end
`endif
        end else begin
          state_next = TAIL;
          tail_load  = 1'b1;
        end
      end
      TAIL: begin
        if (!hold_ack)           state_next = REQ;
        else if (!empty)         state_next = WRITE;
        else if (tail_cnt == '0) state_next = IDLE;
        else                     tail_dec   = 1'b1;
      end
`ifdef ZRAM_WRITER_VERIFY_EN
      VERIFY: state_next = hold_ack ? CHECK : REQ;
      CHECK: begin
        if (!hold_ack) begin
          state_next = REQ;
        end else begin
          chk = 1'b1;
          if (!empty) begin
            state_next = WRITE;
          end else begin
            state_next = TAIL;
            tail_load  = 1'b1;
          end
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    wr_address = head.address;
    wr_data    = head.data;
`ifdef ZRAM_WRITER_VERIFY_EN
    if (state == VERIFY || state == CHECK) begin
      wr_address = last_wr.address;
      wr_data    = last_wr.data;
    end
`endif
  end

  // Port A belongs to the writer exactly while hold_ack is high; tz80 writes are gated off then.
  assign mem_address = hold_ack ? wr_address : cpu_address;
  assign mem_data    = hold_ack ? wr_data    : cpu_o_data;
  assign mem_we      = hold_ack ? wr_fire    : cpu_we;
  assign hold_req    = (state != IDLE);
  assign busy        = !empty || hold_req;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tail_cnt <= '0;
      wr_count <= '0;
    end else begin
      state <= state_next;
      if (tail_load)     tail_cnt <= TAIL_W'(HOLD_TAIL);
      else if (tail_dec) tail_cnt <= tail_cnt - 1'b1;
      if (wr_fire && wr_count != WR_COUNT_MAX) wr_count <= wr_count + 1'b1;
    end
  end

`ifdef ZRAM_WRITER_VERIFY_EN
  // mem_q in CHECK is the registered read of the address presented during VERIFY.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_wr     <= '0;
      verify_err  <= 1'b0;
      err_address <= '0;
    end else begin
      if (wr_fire) last_wr <= head;
      if (chk && mem_q != last_wr.data && !verify_err) begin
        verify_err  <= 1'b1;
        err_address <= last_wr.address;
      end
    end
  end
`endif

endmodule

// File: doc/zram_writer.md
Name: zram_writer

Overview:
- Write-side companion to the video adapter's read port on the shared 64 KB zram.
- Accepts a byte stream of (address, data) writes from a loader source, such as a UART or debug bridge, and buffers them in a small FIFO.
- Takes zram port A away from tz80 through a hold request/acknowledge handshake, then issues the buffered writes.
- Lets the team load programs and video data without resynthesis. It sits between tz80 and zram port A in the top level.

Parameters:
- FIFO_DEPTH, 16: entries in the request FIFO; must be a power of 2, 2..256.
- HOLD_TAIL, 4: idle cycles after the FIFO drains before hold_req is released.

Ports:
- clock  in  1  system clock (clock_50 domain)
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  source has a write request
- in_ready  out  1  FIFO can accept; a transfer happens when in_valid && in_ready
- in_address  in  16  target zram address
- in_data  in  8  byte to write
- hold_req  out  1  request ownership of zram port A (top level holds tz80 reset/stalled)
- hold_ack  in  1  ownership granted; must stay high while hold_req is high
- cpu_address  in  16  tz80 address
- cpu_o_data  in  8  tz80 write data
- cpu_we  in  1  tz80 write enable
- mem_address  out  16  to zram address_a
- mem_data  out  8  to zram data_a
- mem_we  out  1  to zram wren_a
- busy  out  1  FIFO non-empty or hold_req high
- wr_count  out  17  bytes written since reset; saturates at 65536

Behaviour:
Reset values:
- hold_req=0, mem_we=0, wr_count=0, FIFO empty, in_ready=1, state IDLE.
- While hold_ack=0, port A is a passthrough: mem_address=cpu_address, mem_data=cpu_o_data, mem_we=cpu_we.

FIFO:
- in_ready = !full.
- A push when full is ignored; the source must wait.
- A simultaneous push and pop with the FIFO full is allowed; the count is unchanged.
- Pointers wrap modulo FIFO_DEPTH.

FSM states: IDLE, REQ, WRITE, TAIL.
- IDLE: when the FIFO is non-empty, go to REQ and set hold_req=1 on the next edge.
- REQ: wait for hold_ack=1. Once it is high, port A switches to writer ownership combinationally, and the state moves to WRITE on the same edge.
- WRITE: one write per cycle while the FIFO is non-empty.
  - mem_we=1, mem_address/mem_data = FIFO head.
  - Pop on the same edge; wr_count increments.
  - When the FIFO becomes empty, go to TAIL with a counter of HOLD_TAIL.
- TAIL: mem_we=0.
  - If a new entry arrives, return to WRITE.
  - When the counter reaches 0, drop hold_req and go to IDLE.
- Back-to-back pushes sustain 1 write per clock.
- Latency from the first push, with hold_ack already high, to mem_we is 2 cycles.

Boundary and error conditions:
- While hold_ack=1, cpu_we is ignored (gated off).
- If hold_ack falls while in WRITE or TAIL (protocol error), the FSM suspends at once: mem_we=0, no pop. It returns to REQ with hold_req kept high.
- Reset mid-operation clears the FIFO; pending writes are discarded and hold_req drops asynchronously.
- Address 16'hFFFF followed by 16'h0000 needs no special case; addresses are fully independent.

Optional Feature:
- Macro ZRAM_WRITER_VERIFY_EN.
- When defined:
  - Adds input mem_q[7:0] (zram q_a) and outputs verify_err (1, sticky until reset) and err_address (16).
  - After each write, the FSM spends one VERIFY cycle re-presenting the same address with mem_we=0. On the next cycle it compares mem_q with the written byte.
  - On a mismatch: set verify_err and latch err_address; the first error wins.
  - Throughput drops to 1 write per 3 clocks.
- When not defined: none of these ports exist, and timing is as above.

Decomposition:
- Package zram_writer_pkg holds the state enum (IDLE, REQ, WRITE, TAIL, VERIFY, CHECK) and the width constants ADDR_W=16 and DATA_W=8.
- One sub-module, zram_writer_fifo: a synchronous FIFO with a 24-bit entry {address, data}, full/empty flags, async active-high reset, and FIFO_DEPTH as a parameter.

Test Plan:
1. Reset, then cpu_we=1, cpu_address=16'h1234, cpu_o_data=8'hA5 with no pushes -> mem_* mirror the CPU exactly; hold_req stays 0.
2. Push 3 writes (16'h4000←8'h11, 16'h4001←8'h22, 16'hFFFF←8'h33), hold_ack tied to hold_req delayed 1 cycle -> three consecutive mem_we pulses with matching address/data. wr_count=3. hold_req drops HOLD_TAIL+1 cycles after the last write.
3. Push 16 entries with hold_ack held 0 -> in_ready=0 after the 16th; a 17th push is ignored. After hold_ack rises -> exactly 16 writes.
4. Drop hold_ack for 2 cycles in the middle of a burst of 8 -> no mem_we during the drop. All 8 bytes are still written, in order, with none duplicated.
5. Assert reset for 1 cycle mid-burst with 5 entries queued -> hold_req=0, mem_we=0, wr_count=0 immediately. in_ready=1 after release.
6. With ZRAM_WRITER_VERIFY_EN, the model corrupts the read at 16'h0100 -> verify_err=1 and err_address=16'h0100. A later mismatch does not change err_address.
